// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared widths, sweep FSM states and the in-flight sample tag
// Contents:
//   N_IN          number of function inputs
//   TT_W          truth-table width (2**N_IN)
//   sweep_state_e sweep controller states
//   sample_t      {valid, index} tag carried alongside the function latency
package tt_sweep_pkg;
    localparam int N_IN = 7;
    localparam int TT_W = 2 ** N_IN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } sweep_state_e;

    typedef struct packed {
        logic            valid;
        logic [N_IN-1:0] idx;
    } sample_t;
endpackage

// File: rtl/tt_sample_pipe.sv
// tt_sample_pipe: DEPTH-deep shift register of {valid, index} tags matching the function latency
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_flush  in   synchronous clear of every stage
//   i_sample in   tag for the vector issued this cycle
//   o_sample out  tag for the vector whose result is on f_out this cycle
module tt_sample_pipe
    import tt_sweep_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_flush,
    input  sample_t i_sample,
    output sample_t o_sample
);
    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst_n, i_flush};
        assign o_sample = i_sample;
    end else begin : g_pipe
        sample_t r_stage [DEPTH];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            end else if (i_flush) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            end else begin
                r_stage[0] <= i_sample;
                for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end
        assign o_sample = r_stage[DEPTH-1];
    end
endmodule

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps all 2**N_IN input vectors and captures the function's truth table
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a sweep (honoured in IDLE or DONE)
//   abort  in   synchronous cancel back to IDLE, no done
//   x      out  input vector driven to the function under test
//   f_out  in   function output for the x issued DUT_LAT cycles earlier
//   busy   out  high from first issued vector until last sample captured
//   done   out  one-cycle pulse when the table is complete
//   tt     out  captured table, tt[i] = f(x=i)
//   ones   out  popcount of tt
//   match  out  tt == EXPECTED, valid from done until next start
// N_IN must equal tt_sweep_pkg::N_IN since the sample tag width comes from the package.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int                   N_IN     = 7,
    parameter int                   DUT_LAT  = 0,
    parameter logic [2**N_IN-1:0]   EXPECTED = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      x,
    input  logic                 f_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt,
    output logic [N_IN:0]        ones,
    output logic                 match
);
    localparam int TW = 2 ** N_IN;

    sweep_state_e    r_state, w_next;
    logic [N_IN:0]   r_cnt, w_cnt_next;
    logic [TW-1:0]   r_tt, w_tt_next;
    logic [N_IN:0]   r_ones, w_ones_next;
    logic            r_done, r_match;
    logic            w_start, w_last, w_drained, w_enter;
    sample_t         w_issue, w_sample;

    assign w_start   = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last    = r_cnt == (N_IN+1)'(TW - 1);
    // The counter keeps running through DRAIN, so drain end is an absolute count.
    assign w_drained = r_cnt == (N_IN+1)'(TW + DUT_LAT - 1);
    assign w_enter   = w_next == S_DONE && r_state != S_DONE;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_next     = S_SWEEP;
                    w_cnt_next = '0;
                end
            end
            S_SWEEP: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_last) w_next = DUT_LAT > 0 ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_drained) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
        end
    end

    assign w_issue.valid = r_state == S_SWEEP;
    assign w_issue.idx   = r_cnt[N_IN-1:0];

    tt_sample_pipe #(.DEPTH(DUT_LAT)) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (abort),
        .i_sample (w_issue),
        .o_sample (w_sample)
    );

    // Capture is not gated by abort: a sample already emerging is kept as partial content.
    always_comb begin
        w_tt_next   = r_tt;
        w_ones_next = r_ones;
        if (w_start) begin
            w_tt_next   = '0;
            w_ones_next = '0;
        end else if (w_sample.valid) begin
            w_tt_next[w_sample.idx] = f_out;
            w_ones_next             = r_ones + {{N_IN{1'b0}}, f_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tt    <= '0;
            r_ones  <= '0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_tt    <= w_tt_next;
            r_ones  <= w_ones_next;
            r_done  <= w_enter;
            // Compare against the next table so the final capture is included on DONE entry.
            r_match <= (w_start || abort) ? 1'b0 : w_enter ? (w_tt_next == EXPECTED) : r_match;
        end
    end

    assign x     = r_state == S_SWEEP ? r_cnt[N_IN-1:0] : '0;
    assign busy  = r_state == S_SWEEP || r_state == S_DRAIN;
    assign done  = r_done;
    assign tt    = r_tt;
    assign ones  = r_ones;
    assign match = r_match;
endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: directed checks of tt_sweep_capture at DUT_LAT 0 and 3
module tb_tt_sweep_capture;
    localparam logic [127:0] EXP0 = {64{2'b10}};
    localparam logic [127:0] EXP3 = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st = 1'b0, ab = 1'b0, sel = 1'b0;
    int           fsel = 0;
    int           checks = 0, failures = 0;

    logic         start0, abort0, f_out0, busy0, done0, match0;
    logic         start3, abort3, f_out3, busy3, done3, match3;
    logic [6:0]   x0, x3;
    logic [127:0] tt0, tt3;
    logic [7:0]   ones0, ones3;
    logic         d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;

    logic         m_busy, m_done, m_match;
    logic [6:0]   m_x;
    logic [127:0] m_tt;
    logic [7:0]   m_ones;

    always #5 clk = ~clk;

    function automatic logic fn(input int s, input logic [6:0] v);
        case (s)
            0: fn = v[0];
            1: fn = v[6];
            2: fn = &v;
            default: fn = 1'b1;
        endcase
    endfunction

    assign start0 = st & ~sel;
    assign abort0 = ab & ~sel;
    assign start3 = st & sel;
    assign abort3 = ab & sel;
    assign f_out0 = fn(fsel, x0);
    assign f_out3 = d3;

    always @(posedge clk) begin
        d1 <= fn(fsel, x3);
        d2 <= d1;
        d3 <= d2;
    end

    assign m_busy  = sel ? busy3 : busy0;
    assign m_done  = sel ? done3 : done0;
    assign m_match = sel ? match3 : match0;
    assign m_x     = sel ? x3 : x0;
    assign m_tt    = sel ? tt3 : tt0;
    assign m_ones  = sel ? ones3 : ones0;

    tt_sweep_capture #(.N_IN(7), .DUT_LAT(0), .EXPECTED(EXP0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .x(x0), .f_out(f_out0),
        .busy(busy0), .done(done0), .tt(tt0), .ones(ones0), .match(match0)
    );

    tt_sweep_capture #(.N_IN(7), .DUT_LAT(3), .EXPECTED(EXP3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .x(x3), .f_out(f_out3),
        .busy(busy3), .done(done3), .tt(tt3), .ones(ones3), .match(match3)
    );

    task automatic pulse_start();
        @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
    endtask

    // Called in the first cycle after the start edge; returns at the done cycle (or timeout).
    task automatic wait_done(output int n, output int nb, output logic [6:0] xf,
                             output logic [6:0] x51, output logic bd);
        n = 1; nb = 0; xf = m_x; x51 = '1;
        while (m_done !== 1'b1 && n < 400) begin
            nb += int'(m_busy);
            if (n == 51) x51 = m_x;
            @(negedge clk);
            n++;
        end
        bd = m_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({x0, busy0, done0, tt0, ones0, match0} !== '0) begin
            failures++;
            $display("FAIL reset_u0 got x=%0d busy=%b done=%b tt=%h ones=%0d match=%b want all 0",
                     x0, busy0, done0, tt0, ones0, match0);
        end
        checks++;
        if ({x3, busy3, done3, tt3, ones3, match3} !== '0) begin
            failures++;
            $display("FAIL reset_u3 got x=%0d busy=%b done=%b tt=%h ones=%0d match=%b want all 0",
                     x3, busy3, done3, tt3, ones3, match3);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_x0_lat0();
        int n, nb; logic [6:0] xf, x51; logic bd;
        sel = 1'b0; fsel = 0;
        pulse_start();
        wait_done(n, nb, xf, x51, bd);
        checks++;
        if (n != 129 || nb != 128 || bd !== 1'b0) begin
            failures++;
            $display("FAIL x0_timing got done_cycle=%0d busy_cycles=%0d busy_at_done=%b want 129 128 0", n, nb, bd);
        end
        checks++;
        if (xf !== 7'd0 || x51 !== 7'd50) begin
            failures++;
            $display("FAIL x0_issue got x@1=%0d x@51=%0d want 0 50", xf, x51);
        end
        checks++;
        if (m_tt !== EXP0 || m_ones !== 8'd64 || m_match !== 1'b1) begin
            failures++;
            $display("FAIL x0_table got tt=%h ones=%0d match=%b want %h 64 1", m_tt, m_ones, m_match, EXP0);
        end
        @(negedge clk);
        checks++;
        if (m_done !== 1'b0 || m_x !== 7'd0 || m_tt !== EXP0 || m_match !== 1'b1) begin
            failures++;
            $display("FAIL x0_hold got done=%b x=%0d tt=%h match=%b want 0 0 %h 1", m_done, m_x, m_tt, m_match, EXP0);
        end
    endtask

    task automatic test_x6_lat3();
        int n, nb; logic [6:0] xf, x51; logic bd;
        sel = 1'b1; fsel = 1;
        pulse_start();
        wait_done(n, nb, xf, x51, bd);
        checks++;
        if (n != 132 || nb != 131 || bd !== 1'b0) begin
            failures++;
            $display("FAIL x6_timing got done_cycle=%0d busy_cycles=%0d busy_at_done=%b want 132 131 0", n, nb, bd);
        end
        checks++;
        if (m_tt !== EXP3 || m_ones !== 8'd64 || m_match !== 1'b1) begin
            failures++;
            $display("FAIL x6_table got tt=%h ones=%0d match=%b want %h 64 1", m_tt, m_ones, m_match, EXP3);
        end
        @(negedge clk);
    endtask

    task automatic test_and();
        int n, nb; logic [6:0] xf, x51; logic bd;
        sel = 1'b0; fsel = 2;
        pulse_start();
        wait_done(n, nb, xf, x51, bd);
        checks++;
        if (n != 129 || m_tt !== (128'd1 << 127) || m_ones !== 8'd1 || m_match !== 1'b0) begin
            failures++;
            $display("FAIL and_table got n=%0d tt=%h ones=%0d match=%b want 129 bit127 1 0", n, m_tt, m_ones, m_match);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int k, nd;
        sel = 1'b0; fsel = 3;
        pulse_start();
        k = 0;
        while (m_x !== 7'd40 && k < 400) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 400) begin
            failures++;
            $display("FAIL abort_reach got x=%0d want 40 within bound", m_x);
        end
        ab = 1'b1; st = 1'b1;
        @(negedge clk);
        ab = 1'b0; st = 1'b0;
        checks++;
        if (m_busy !== 1'b0 || m_x !== 7'd0 || m_done !== 1'b0 || m_ones !== 8'd41 || m_match !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got busy=%b x=%0d done=%b ones=%0d match=%b want 0 0 0 41 0",
                     m_busy, m_x, m_done, m_ones, m_match);
        end
        checks++;
        if (m_tt !== ((128'd1 << 41) - 128'd1)) begin
            failures++;
            $display("FAIL abort_tt got tt=%h want bits 0..40", m_tt);
        end
        nd = 0;
        repeat (140) begin
            @(negedge clk);
            nd += int'(m_done) + int'(m_busy);
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL abort_quiet got done_or_busy_cycles=%0d want 0", nd);
        end
    endtask

    task automatic test_reset_mid();
        int n, nb, k; logic [6:0] xf, x51; logic bd;
        sel = 1'b0; fsel = 0;
        pulse_start();
        k = 0;
        while (m_x !== 7'd90 && k < 400) begin
            @(negedge clk);
            k++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (k >= 400 || {x0, busy0, done0, tt0, ones0, match0} !== '0) begin
            failures++;
            $display("FAIL reset_mid got k=%0d x=%0d busy=%b done=%b ones=%0d match=%b want all 0",
                     k, x0, busy0, done0, ones0, match0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        wait_done(n, nb, xf, x51, bd);
        checks++;
        if (n != 129 || m_tt !== EXP0 || m_ones !== 8'd64 || m_match !== 1'b1) begin
            failures++;
            $display("FAIL reset_rerun got n=%0d tt=%h ones=%0d match=%b want 129 %h 64 1", n, m_tt, m_ones, m_match, EXP0);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, nb; logic [6:0] xf, x51; logic bd;
        sel = 1'b1; fsel = 1;
        pulse_start();
        repeat (9) @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        checks++;
        if (m_x !== 7'd10 || m_busy !== 1'b1) begin
            failures++;
            $display("FAIL ignored_start got x=%0d busy=%b want 10 1", m_x, m_busy);
        end
        n = 11;
        while (m_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 132 || m_tt !== EXP3 || m_match !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got n=%0d tt=%h match=%b want 132 %h 1", n, m_tt, m_match, EXP3);
        end
        st = 1'b1; fsel = 2;
        @(negedge clk);
        st = 1'b0;
        checks++;
        if (m_x !== 7'd0 || m_busy !== 1'b1 || m_done !== 1'b0 || m_tt !== '0 || m_ones !== 8'd0 || m_match !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart got x=%0d busy=%b done=%b tt=%h ones=%0d match=%b want 0 1 0 0 0 0",
                     m_x, m_busy, m_done, m_tt, m_ones, m_match);
        end
        wait_done(n, nb, xf, x51, bd);
        checks++;
        if (n != 132 || nb != 131 || m_tt !== (128'd1 << 127) || m_ones !== 8'd1 || m_match !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got n=%0d busy_cycles=%0d tt=%h ones=%0d match=%b want 132 131 bit127 1 0",
                     n, nb, m_tt, m_ones, m_match);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_x0_lat0();
        test_x6_lat3();
        test_and();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Sequential harness stage that feeds a 7-input combinational classification function and consumes its output. It enumerates all 128 input vectors on `x`, samples the function's single-bit output, and assembles the full 128-bit truth table. It also reports the on-set size and whether the table equals a parameterised expected signature. It sits directly in front of, and behind, one function-under-test instance in the classification flow.

## Interface
Parameters:
- `N_IN`, 7, number of function inputs; truth-table width is 2**N_IN (128)
- `DUT_LAT`, 0, cycles from `x` change to valid `f_out` (0 = purely combinational, max 4)
- `EXPECTED`, 128'h0, reference signature for the `match` output

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE
- `abort`  in  1  synchronous cancel; returns to IDLE with no `done`
- `x`  out  N_IN  input vector driven to the function (`x[0]` = input x0, LSB)
- `f_out`  in  1  function output corresponding to `x` issued `DUT_LAT` cycles earlier
- `busy`  out  1  high from first issued vector until last sample captured
- `done`  out  1  one-cycle pulse when the table is complete
- `tt`  out  2**N_IN  captured truth table, `tt[i]` = f(x=i)
- `ones`  out  N_IN+1  popcount of `tt` (0..128)
- `match`  out  1  `tt == EXPECTED`; valid from `done` until next `start`

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: `x`=0, `busy`=0. `start` -> SWEEP; `tt`, `ones`, and `match` clear on the same edge.
- SWEEP: issue counter drives `x`, incrementing by 1 each cycle from 0 to 127. After issuing 127: -> DRAIN if `DUT_LAT`>0, else -> DONE.
- DRAIN: waits `DUT_LAT` cycles for in-flight samples, then -> DONE.
- Capture: a delay line of depth `DUT_LAT` carries {valid, index} alongside the function. On each valid sample, write `tt[index] <= f_out` and add `f_out` to `ones`.
- DONE: `done`=1 for exactly one cycle on entry. `match` is registered that same cycle. The state holds `tt`/`ones`/`match` until the next `start` (-> SWEEP). `x` returns to 0.
- `start` during SWEEP or DRAIN is ignored.
- `abort` in any state -> IDLE next edge. It flushes the delay line; `tt` and `ones` keep partial contents; `match`=0.
- `abort` and `start` in the same cycle: `abort` wins.
- Arithmetic: the issue counter is N_IN+1 bits, so terminal detection does not wrap. `ones` is N_IN+1 bits and cannot overflow (max 128).

## Timing
- Reset values: `x`=0, `busy`=0, `done`=0, `tt`=0, `ones`=0, `match`=0; state IDLE; delay line invalid.
- Reset mid-sweep aborts immediately with the same values; no `done`.
- `start` sampled at edge T: `busy`=1 and `x`=0 from T+1; `x`=k at T+1+k.
- Sample for vector k is captured at edge T+2+k+`DUT_LAT`.
- `done` is high in cycle T+129+`DUT_LAT`, with `busy` low in that same cycle. Sweep latency is 129+`DUT_LAT` cycles.
- `busy` is high for exactly 128+`DUT_LAT` cycles.
- Back-to-back: `start` accepted in the `done` cycle begins the next sweep with no gap cycle.

## Structure
- Shared package `tt_sweep_pkg`: `N_IN`, `TT_W = 2**N_IN`, state enum `sweep_state_e`, and the `{valid, index}` struct type.
- One sub-module, `tt_sample_pipe`: a parameterised `DUT_LAT`-deep shift register of {valid, index} with synchronous flush. Depth 0 is a pass-through.
- The top level holds the FSM, issue counter, table register, popcount accumulator, and compare.

## Test plan
- Stub f = x0, `DUT_LAT`=0, start -> `done` at cycle 129 after start; `tt`=128'hAAAA…AAAA; `ones`=64.
- Stub f = x6, `DUT_LAT`=3, `EXPECTED`=128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000 -> `done` at cycle 132; `match`=1; `ones`=64.
- Stub f = AND of all inputs, `EXPECTED`=0 -> `tt` has only bit 127 set; `ones`=1; `match`=0.
- Abort at `x`=40 (f = 1 constant) -> IDLE next cycle; no `done`; `ones`=41 for `DUT_LAT`=0. A `start` in that same cycle is ignored.
- `rst_n` low at `x`=90 -> all outputs 0 asynchronously. A fresh `start` after release completes a correct full table.
- `start` pulsed during SWEEP is ignored. `start` in the `done` cycle begins the next sweep with `x`=0 on the following cycle. The second table is correct.
